// File: rtl/instr_fetch.sv
// instr_fetch: MIPS32 instruction-fetch stage; owns the PC, drives the instruction ROM and fills the IF/ID register.
// Ports:
//   clk, rst_n        pipeline clock, asynchronous active-low reset
//   i_stall           hold PC and IF/ID this cycle
//   i_flush           discard IF/ID and load PC from i_flush_addr (beats stall and branch)
//   i_flush_addr      PC target on flush (low two bits dropped)
//   i_branch_flag     taken branch/jump resolved in ID
//   i_branch_target   PC target on taken branch (low two bits dropped)
//   o_rom_ce          ROM chip enable, high from the first edge after reset release
//   o_rom_addr        ROM byte address, equal to the PC
//   i_rom_instr       combinational ROM read data for o_rom_addr
//   o_id_pc           PC of the instruction held in IF/ID
//   o_id_instr        instruction held in IF/ID, 0 for a bubble
//   o_id_valid        IF/ID holds a real fetched instruction
//   o_fetch_cnt       instructions delivered to ID, wraps modulo 2^32
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_flush_addr,
  input  logic        i_branch_flag,
  input  logic [31:0] i_branch_target,
  output logic        o_rom_ce,
  output logic [31:0] o_rom_addr,
  input  logic [31:0] i_rom_instr,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr,
  output logic        o_id_valid,
  output logic [31:0] o_fetch_cnt
);
  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic        r_id_valid;
  logic [31:0] r_fetch_cnt;
  // Masking keeps every address bit in use while forcing word alignment.
  logic [31:0] w_flush_pc;
  logic [31:0] w_branch_pc;
  assign w_flush_pc  = i_flush_addr & 32'hFFFF_FFFC;
  assign w_branch_pc = i_branch_target & 32'hFFFF_FFFC;
  assign o_rom_ce    = (r_state == S_RUN);
  assign o_rom_addr  = r_pc;
  assign o_id_pc     = r_id_pc;
  assign o_id_instr  = r_id_instr;
  assign o_id_valid  = r_id_valid;
  assign o_fetch_cnt = r_fetch_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC & 32'hFFFF_FFFC;
      r_id_pc     <= '0;
      r_id_instr  <= '0;
      r_id_valid  <= 1'b0;
      r_fetch_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_state <= S_RUN;
    end else if (i_flush) begin
      r_pc       <= w_flush_pc;
      r_id_pc    <= '0;
      r_id_instr <= '0;
      r_id_valid <= 1'b0;
    end else if (i_stall) begin
      // ID is frozen too, so a pending branch is re-presented once the stall drops.
    end else if (i_branch_flag) begin
      r_pc <= w_branch_pc;
      if (DELAY_SLOT) begin
        r_id_pc     <= r_pc;
        r_id_instr  <= i_rom_instr;
        r_id_valid  <= 1'b1;
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end else begin
        r_id_pc    <= '0;
        r_id_instr <= '0;
        r_id_valid <= 1'b0;
      end
    end else begin
      r_pc        <= r_pc + 32'd4;
      r_id_pc     <= r_pc;
      r_id_instr  <= i_rom_instr;
      r_id_valid  <= 1'b1;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end
endmodule
